// File: rtl/jt51_ch8_acc.sv
// Channel-8 carrier accumulator: sums the carrier operators of channel 8 over a
// 32-slot frame, with noise replacing operator 31, and emits left/right samples.
// Optional macro JT51_CH8_SAT_EN: clamp the output to the OUTW signed range
// instead of wrapping.
module jt51_ch8_acc #(
    parameter int OPW  = 14,
    parameter int OUTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   zero,
    input  logic signed [OPW-1:0]  op_out,
    input  logic        [10:0]     noise,
    input  logic                   ne,
    input  logic        [2:0]      alg,
    input  logic        [1:0]      rl,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample
);

    localparam int ACCW = OPW + 3;

    localparam logic [4:0] SLOT_M1 = 5'd7;
    localparam logic [4:0] SLOT_M2 = 5'd15;
    localparam logic [4:0] SLOT_C1 = 5'd23;
    localparam logic [4:0] SLOT_C2 = 5'd31;

    // Mask bit order: [0]=M1, [1]=M2, [2]=C1, [3]=C2.
    function automatic logic [3:0] carrier_mask(input logic [2:0] a);
        logic [3:0] m;
        case (a)
            3'd7:       m = 4'b1111;
            3'd5, 3'd6: m = 4'b1110;
            3'd4:       m = 4'b1100;
            default:    m = 4'b1000;
        endcase
        return m;
    endfunction

`ifdef JT51_CH8_SAT_EN
    localparam int SW = ((ACCW > OUTW) ? ACCW : OUTW) + 1;
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (OUTW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = SW'(-(64'sd1 <<< (OUTW - 1)));

    function automatic logic signed [OUTW-1:0] fit_out(input logic signed [ACCW-1:0] v);
        logic signed [SW-1:0] w;
        w = SW'(v);
        if (w > MAXV) begin
            return MAXV[OUTW-1:0];
        end
        if (w < MINV) begin
            return MINV[OUTW-1:0];
        end
        return w[OUTW-1:0];
    endfunction
`else
    function automatic logic signed [OUTW-1:0] fit_out(input logic signed [ACCW-1:0] v);
        return OUTW'(v);
    endfunction
`endif

    logic        [4:0]      slot_q, slot_d, slot;
    logic        [3:0]      mask_q, mask_d, alg_mask;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [OUTW-1:0] left_q, left_d, right_q, right_d;
    logic                   sample_q, sample_d;
    logic signed [ACCW-1:0] op_ext, last_ext, acc_final;
    logic signed [OPW-1:0]  noise_op, last_op;
    logic signed [OUTW-1:0] sum;

    always_comb begin
        slot      = zero ? 5'd0 : slot_q;
        slot_d    = slot + 5'd1;
        mask_d    = mask_q;
        acc_d     = acc_q;
        left_d    = left_q;
        right_d   = right_q;
        sample_d  = 1'b0;
        alg_mask  = carrier_mask(alg);
        op_ext    = ACCW'(op_out);
        noise_op  = OPW'($signed(noise)) <<< 3;
        last_op   = ne ? noise_op : op_out;
        last_ext  = ACCW'(last_op);
        acc_final = acc_q + (mask_q[3] ? last_ext : '0);
        sum       = fit_out(acc_final);

        case (slot)
            // Slot 7 loads rather than adds, so the previous frame is dropped here.
            SLOT_M1: begin
                mask_d = alg_mask;
                acc_d  = alg_mask[0] ? op_ext : '0;
            end
            SLOT_M2: begin
                if (mask_q[1]) begin
                    acc_d = acc_q + op_ext;
                end
            end
            SLOT_C1: begin
                if (mask_q[2]) begin
                    acc_d = acc_q + op_ext;
                end
            end
            SLOT_C2: begin
                left_d   = rl[0] ? sum : '0;
                right_d  = rl[1] ? sum : '0;
                sample_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            mask_q   <= '0;
            acc_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            mask_q   <= mask_d;
            acc_q    <= acc_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
        end
    end

    assign left   = left_q;
    assign right  = right_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_jt51_ch8_acc.sv
// Directed table-driven bench for jt51_ch8_acc at OUTW=16 and an OUTW=15 copy
// used to exercise the overflow behaviour (clamp or wrap depending on the macro).
module tb_jt51_ch8_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic               zero;
    logic signed [13:0] op_out;
    logic        [10:0] noise;
    logic               ne;
    logic        [2:0]  alg;
    logic        [1:0]  rl;
    logic signed [15:0] left16, right16;
    logic               sample16;
    logic signed [14:0] left15, right15;
    logic               sample15;

    always #5 clk = ~clk;

    jt51_ch8_acc #(.OPW(14), .OUTW(16)) u16 (
        .clk(clk), .rst(rst), .zero(zero), .op_out(op_out), .noise(noise),
        .ne(ne), .alg(alg), .rl(rl),
        .left(left16), .right(right16), .sample(sample16)
    );

    jt51_ch8_acc #(.OPW(14), .OUTW(15)) u15 (
        .clk(clk), .rst(rst), .zero(zero), .op_out(op_out), .noise(noise),
        .ne(ne), .alg(alg), .rl(rl),
        .left(left15), .right(right15), .sample(sample15)
    );

    typedef struct {
        logic [2:0]  alg;
        logic        ne;
        logic [10:0] noise;
        logic [1:0]  rl;
        int          op7, op15, op23, op31, oth;
        int          sum16, sat15, wrap15;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int last_l16 = 0, last_r16 = 0, last_l15 = 0, last_r15 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] a, input logic n, input logic [10:0] nz,
                                input logic [1:0] r, input int o7, input int o15,
                                input int o23, input int o31, input int ot,
                                input int s16, input int s15, input int w15);
        vec_t v;
        v.alg = a; v.ne = n; v.noise = nz; v.rl = r;
        v.op7 = o7; v.op15 = o15; v.op23 = o23; v.op31 = o31; v.oth = ot;
        v.sum16 = s16; v.sat15 = s15; v.wrap15 = w15;
        return v;
    endfunction

    task automatic set_inputs(input vec_t v, input int s);
        int o;
        zero  = (s == 0);
        alg   = v.alg;
        ne    = v.ne;
        noise = v.noise;
        rl    = v.rl;
        case (s)
            7:       o = v.op7;
            15:      o = v.op15;
            23:      o = v.op23;
            31:      o = v.op31;
            default: o = v.oth;
        endcase
        op_out = 14'(o);
    endtask

    // Drives nslots slots starting with a zero marker; a full frame is checked
    // at the following slot 0 against the expected sums.
    task automatic run_frame(input string name, input vec_t v, input int nslots);
        int bad_s, bad_h, e15, el16, er16, el15, er15;
        bad_s = 0;
        bad_h = 0;
        for (int s = 0; s < nslots; s++) begin
            set_inputs(v, s);
            if (s > 0) begin
                if (sample16 || sample15) bad_s++;
                if (int'(left16) != last_l16 || int'(right16) != last_r16 ||
                    int'(left15) != last_l15 || int'(right15) != last_r15) bad_h++;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_nopulse"}, bad_s, 0);
        chk({name, "_hold"}, bad_h, 0);
        if (nslots == 32) begin
`ifdef JT51_CH8_SAT_EN
            e15 = v.sat15;
`else
            e15 = v.wrap15;
`endif
            el16 = v.rl[0] ? v.sum16 : 0;
            er16 = v.rl[1] ? v.sum16 : 0;
            el15 = v.rl[0] ? e15 : 0;
            er15 = v.rl[1] ? e15 : 0;
            chk({name, "_sample16"}, int'(sample16), 1);
            chk({name, "_sample15"}, int'(sample15), 1);
            chk({name, "_left16"}, int'(left16), el16);
            chk({name, "_right16"}, int'(right16), er16);
            chk({name, "_left15"}, int'(left15), el15);
            chk({name, "_right15"}, int'(right15), er15);
            last_l16 = el16; last_r16 = er16;
            last_l15 = el15; last_r15 = er15;
        end
    endtask

    task automatic chk_zero_out(input string name);
        chk({name, "_left16"}, int'(left16), 0);
        chk({name, "_right16"}, int'(right16), 0);
        chk({name, "_sample16"}, int'(sample16), 0);
        chk({name, "_out15"}, int'(left15) | int'(right15) | int'(sample15), 0);
    endtask

    vec_t tbl[10];
    vec_t va, vb, vc;

    initial begin
        tbl[0] = mk(3'd0, 1'b0, 11'h155, 2'd3, 100, 100, 100, 100, 100, 100, 100, 100);
        tbl[1] = mk(3'd7, 1'b0, 11'h2AA, 2'd1, 1000, 1000, 1000, 1000, 0, 4000, 4000, 4000);
        tbl[2] = mk(3'd4, 1'b1, 11'h3FF, 2'd3, 777, 777, 50, 8191, 0, 8234, 8234, 8234);
        tbl[3] = mk(3'd7, 1'b0, 11'h000, 2'd3, 8191, 8191, 8191, 8191, 0, 32764, 16383, -4);
        tbl[4] = mk(3'd7, 1'b1, 11'h3FF, 2'd3, 8191, 8191, 8191, 8191, 0, 32757, 16383, -11);
        tbl[5] = mk(3'd7, 1'b0, 11'h000, 2'd3, -8192, -8192, -8192, -8192, 0, -32768, -16384, 0);
        tbl[6] = mk(3'd5, 1'b0, 11'h000, 2'd2, 5, -300, 200, -1000, 7, -1100, -1100, -1100);
        tbl[7] = mk(3'd3, 1'b1, 11'h400, 2'd3, 999, 999, 999, 5, 0, -8192, -8192, -8192);
        tbl[8] = mk(3'd6, 1'b1, 11'h001, 2'd0, 3, 1, 2, 9, 0, 11, 11, 11);
        tbl[9] = mk(3'd2, 1'b0, 11'h000, 2'd1, 40, 40, 40, -1, 40, -1, -1, -1);
        va = mk(3'd7, 1'b0, 11'h000, 2'd3, 1000, 1000, 1000, 1000, 1000, 4000, 4000, 4000);
        vb = mk(3'd0, 1'b0, 11'h000, 2'd3, 123, 123, 123, 123, 123, 123, 123, 123);
        vc = mk(3'd0, 1'b0, 11'h000, 2'd3, 55, 55, 55, 55, 55, 55, 55, 55);

        rst = 1'b1; zero = 1'b0; op_out = '0; noise = '0; ne = 1'b0; alg = '0; rl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_out("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i], 32);
        end

        // Mid-frame zero: the partial frame is abandoned and never reported.
        run_frame("midzero_part", va, 20);
        run_frame("midzero_next", vb, 32);

        // Reset in the middle of a frame, then an aligned frame.
        run_frame("rst_part", va, 20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero_out("rst_mid");
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        last_l16 = 0; last_r16 = 0; last_l15 = 0; last_r15 = 0;
        for (int i = 0; i < 3; i++) begin
            set_inputs(va, 5);
            @(posedge clk);
            #1;
            chk_zero_out($sformatf("post_rst%0d", i));
        end
        run_frame("after_rst", vc, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt51_ch8_acc.md
Name: jt51_ch8_acc

Overview:
- Downstream consumer of the noise generator's 11-bit output.
- Accumulates the carrier operators of channel 8 (index 7) over one 32-slot sample frame, substituting the noise value for operator 31 when noise is enabled.
- Produces saturated left/right channel-8 samples with a one-cycle valid strobe, for the final mixer.

Parameters:
- OPW, 14, width of signed operator output samples.
- OUTW, 16, width of signed left/right output samples.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- zero  in  1  high in the cycle in which slot 0's operator output is on op_out; frame start marker.
- op_out  in  OPW  signed operator output for the current slot.
- noise  in  11  noise sample: bit10 sign, bits9:0 magnitude, treated as 11-bit two's complement.
- ne  in  1  noise enable, sampled at slot 31.
- alg  in  3  channel 8 connection algorithm, sampled at slot 7.
- rl  in  2  channel 8 output enables, sampled at slot 31: bit1 right, bit0 left.
- left  out  OUTW  signed left sample.
- right  out  OUTW  signed right sample.
- sample  out  1  one-cycle strobe: left/right updated this cycle.

Behaviour:
- Slot counter
  - 5 bits, named slot.
  - zero=1 forces slot=0 for the current cycle; otherwise slot = previous+1, wrapping 31->0.
  - After reset, slot counts from 0; the first zero resynchronises it.
- Channel 8 slots: M1=7, M2=15, C1=23, C2=31.
- Carrier mask, latched from alg at slot 7 and held for the frame:
  - alg 0-3: C2 only.
  - alg 4: C1, C2.
  - alg 5-6: M2, C1, C2.
  - alg 7: M1, M2, C1, C2.
- Operand at slot 31 when ne=1: noise sign-extended to OPW bits and shifted left 3 (noise<<<3, LSBs zero) instead of op_out. ne=0 uses op_out.
- Accumulator
  - Signed, OPW+3 bits.
  - At slot 7: acc <= mask(M1)? sext(op_out) : 0. This is a load, not an add, which clears the previous frame.
  - At slots 15 and 23: acc <= acc + (carrier? sext(op_out) : 0).
  - At slot 31: acc + operand (if carrier) goes into the output stage, not back into acc.
- Output stage, registered in the cycle after slot 31 (that cycle is slot 0):
  - sum = acc_final, sign-extended or saturated to OUTW bits.
  - left = rl[0]? sat(sum) : 0.
  - right = rl[1]? sat(sum) : 0.
  - sample=1 for exactly that cycle.
- Latency: 1 cycle from the slot-31 input to a valid output.
- Saturation (see Optional Feature): clamp to +32767 / -32768 when OUTW=16.
- Simultaneous zero with the slot-31 output stage: output still issues; zero only realigns the counter.
- A zero arriving mid-frame (slot != expected 0): counter jumps to 0. The partial acc is discarded by the next slot-7 load, and no sample is emitted until a slot 31 occurs.
- Reset state:
  - Synchronous reset clears slot, acc, mask, left, right and sample.
  - Reset mid-frame suppresses that frame's sample.
- Outputs hold their values between strobes.

Optional Feature:
- Macro: JT51_CH8_SAT_EN.
- Defined: the output stage saturates sum to OUTW signed range.
- Undefined: the output stage truncates to the low OUTW bits (wrap-around); no clamp logic is built.
- The accumulator width is unchanged in both cases.

Test Plan:
- alg=0, ne=0, rl=3, op_out=100 on all slots -> left=right=100, sample pulses at the slot 0 following slot 31.
- alg=7, ne=0, rl=1, op_out=1000 on slots 7/15/23/31 -> left=4000, right=0.
- alg=4, ne=1, noise=11'h3FF (+1023), op_out=0x1FFF on slot 31, op_out=50 at slot 23 -> left=50+8184=8234; the slot-31 op_out is ignored.
- alg=7, op_out=8191 on all four slots, JT51_CH8_SAT_EN defined -> sum 32764, no clamp. With noise=11'h3FF substituted at slot 31 (ne=1): 24573+8184=32757. op_out=-8192 on all four slots -> -32768.
  - Separate overflow check at OUTW=15: both cases clamp to 16383 / -16384 with the macro defined and wrap without it.
- Reset asserted at slot 20, released at slot 25, then zero aligned -> no sample in the interrupted frame. The next full frame produces the correct value, and outputs read 0 until then.
